// File: rtl/seq_carry_unit_pkg.sv
// seq_carry_unit_pkg: shared mode/state encodings and default sizing for seq_carry_unit
package seq_carry_unit_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 2;
  typedef enum logic [1:0] {MODE_PASS = 2'b00, MODE_INC = 2'b01, MODE_DEC = 2'b10, MODE_NEG = 2'b11} mode_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10} state_t;
endpackage

// File: rtl/seq_carry_unit_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple of full adders; ports a, b, cin -> s, cout, c_msb_in (carry into top bit)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    full_adder u_fa (.a(a[g]), .b(b[g]), .cin(c[g]), .s(s[g]), .cout(c[g+1]));
  end
  assign cout = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/seq_carry_unit.sv
// seq_carry_unit: chunked carry-chain PASS/INC/DEC/NEG; clk, reset(async) , start/mode/operand in; busy/done/result/carry_out/overflow/zero out
module seq_carry_unit
  import seq_carry_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state;
  mode_t mode_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
  logic carry, cout, c_msb_in, last, accept;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] sum;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_q[idx*CHUNK +: CHUNK]),
    .b(b_q[idx*CHUNK +: CHUNK]),
    .cin(carry),
    .s(sum),
    .cout(cout),
    .c_msb_in(c_msb_in)
  );
  assign last = idx == IW'(N - 1);
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  // Result registers sample the accumulator including the chunk finished on this edge.
  always_comb begin
    acc_next = acc;
    acc_next[idx*CHUNK +: CHUNK] = sum;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      mode_q <= MODE_PASS;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      carry <= 1'b0;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mode_q <= mode_t'(mode);
        a_q <= mode_t'(mode) == MODE_NEG ? ~operand : operand;
        b_q <= mode_t'(mode) == MODE_DEC ? '1 : '0;
        carry <= mode_t'(mode) == MODE_INC || mode_t'(mode) == MODE_NEG;
        idx <= '0;
        state <= ST_RUN;
        busy <= 1'b1;
      end else if (state == ST_RUN) begin
        acc <= acc_next;
        carry <= cout;
        idx <= idx + 1'b1;
        if (last) begin
          state <= ST_DONE;
          done <= 1'b1;
          result <= acc_next;
          carry_out <= cout;
          overflow <= mode_q != MODE_PASS && (c_msb_in ^ cout);
          zero <= acc_next == '0;
        end
      end else begin
        state <= ST_IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_carry_unit.sv
// tb_seq_carry_unit: randomized self-checking bench for three seq_carry_unit configurations
module tb_seq_carry_unit;
  logic clk = 0, reset = 1;
  logic [1:0] mode = 0;
  logic [15:0] operand = 0;
  logic st0 = 0, st1 = 0, st2 = 0;
  logic dn0, dn1, dn2, by0, by1, by2, co0, co1, co2, ov0, ov1, ov2, zr0, zr1, zr2;
  logic [7:0] r0;
  logic [15:0] r1, r2;
  int tests = 0, fails = 0;
  int wd [3] = '{8, 16, 16};
  int nd [3] = '{4, 4, 1};
  always #5 clk = ~clk;
  seq_carry_unit u0 (.clk(clk), .reset(reset), .start(st0), .mode(mode), .operand(operand[7:0]),
    .busy(by0), .done(dn0), .result(r0), .carry_out(co0), .overflow(ov0), .zero(zr0));
  seq_carry_unit #(.WIDTH(16), .CHUNK(4)) u1 (.clk(clk), .reset(reset), .start(st1), .mode(mode), .operand(operand),
    .busy(by1), .done(dn1), .result(r1), .carry_out(co1), .overflow(ov1), .zero(zr1));
  seq_carry_unit #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .reset(reset), .start(st2), .mode(mode), .operand(operand),
    .busy(by2), .done(dn2), .result(r2), .carry_out(co2), .overflow(ov2), .zero(zr2));

  function automatic logic [15:0] res_of(int d);
    return d == 0 ? {8'h00, r0} : d == 1 ? r1 : r2;
  endfunction
  function automatic logic [3:0] flg_of(int d);
    return d == 0 ? {by0, co0, ov0, zr0} : d == 1 ? {by1, co1, ov1, zr1} : {by2, co2, ov2, zr2};
  endfunction
  function automatic logic dn_of(int d);
    return d == 0 ? dn0 : d == 1 ? dn1 : dn2;
  endfunction
  task automatic set_start(int d, logic v);
    if (d == 0) st0 = v; else if (d == 1) st1 = v; else st2 = v;
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic, flags from signed/unsigned range rules.
  task automatic model(int w, logic [1:0] m, logic [15:0] x, output logic [15:0] r, output logic c, output logic v);
    int mask, minv, xv, s;
    mask = (1 << w) - 1;
    minv = 1 << (w - 1);
    xv = int'(x) & mask;
    case (m)
      2'b00: begin s = xv; v = 0; end
      2'b01: begin s = xv + 1; v = xv == minv - 1; end
      2'b10: begin s = xv + mask; v = xv == minv; end
      default: begin s = (~xv & mask) + 1; v = xv == minv; end
    endcase
    r = 16'(s & mask);
    c = (s >> w) & 1;
  endtask

  task automatic accept_op(int d, logic [1:0] m, logic [15:0] x);
    @(negedge clk);
    mode = m;
    operand = x;
    set_start(d, 1);
    @(posedge clk);
    #1 set_start(d, 0);
  endtask

  task automatic wait_done(int d, output int cyc, output logic bok);
    cyc = 0;
    bok = 1;
    while (!dn_of(d) && cyc < 40) begin
      if (!flg_of(d)[3]) bok = 0;
      @(posedge clk);
      #1 cyc++;
    end
    if (!flg_of(d)[3]) bok = 0;
  endtask

  task automatic run_op(string tag, int d, logic [1:0] m, logic [15:0] x);
    int cyc;
    logic bok, c, v;
    logic [15:0] r;
    accept_op(d, m, x);
    wait_done(d, cyc, bok);
    model(wd[d], m, x, r, c, v);
    check({tag, ".latency"}, cyc, nd[d]);
    check({tag, ".busy"}, bok, 1);
    check({tag, ".result"}, res_of(d), r);
    check({tag, ".flags"}, flg_of(d)[2:0], {c, v, r == 0});
  endtask

  initial begin
    int cyc, cnt;
    logic bok;
    logic [15:0] x, corners [4];
    logic [1:0] m;
    repeat (2) @(posedge clk);
    #1 check("reset.outs", {res_of(0), flg_of(0), dn_of(0)}, 0);
    @(negedge clk) reset = 0;
    check("reset.idle_busy", flg_of(1)[3], 0);
    run_op("inc7f", 0, 2'b01, 16'h7F);
    check("inc7f.exact", {res_of(0), flg_of(0)[2:0]}, {16'h80, 3'b010});
    run_op("incff", 0, 2'b01, 16'hFF);
    check("incff.exact", {res_of(0), flg_of(0)[2:0]}, {16'h00, 3'b101});
    run_op("dec00", 0, 2'b10, 16'h00);
    run_op("dec80", 0, 2'b10, 16'h80);
    check("dec80.exact", {res_of(0), flg_of(0)[2:0]}, {16'h7F, 3'b110});
    run_op("neg05", 0, 2'b11, 16'h05);
    run_op("neg80", 0, 2'b11, 16'h80);
    run_op("neg00", 0, 2'b11, 16'h00);
    check("neg00.exact", {res_of(0), flg_of(0)[2:0]}, {16'h00, 3'b101});
    run_op("passa5", 0, 2'b00, 16'hA5);
    repeat (3) @(posedge clk);
    #1 check("hold.idle", {res_of(0), flg_of(0)}, {16'hA5, 4'b0000});
    // start during RUN must be ignored
    accept_op(0, 2'b01, 16'h10);
    @(posedge clk);
    #1 operand = 16'h00;
    mode = 2'b10;
    st0 = 1;
    @(posedge clk);
    #1 st0 = 0;
    wait_done(0, cyc, bok);
    check("runstart.result", res_of(0), 16'h11);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1 if (dn0) cnt++; end
    check("runstart.no_second", cnt, 0);
    check("runstart.idle", flg_of(0)[3], 0);
    // back-to-back accept in the done cycle
    accept_op(0, 2'b11, 16'h01);
    wait_done(0, cyc, bok);
    check("b2b.first", res_of(0), 16'hFF);
    mode = 2'b01;
    operand = 16'h41;
    st0 = 1;
    @(posedge clk);
    #1 st0 = 0;
    wait_done(0, cyc, bok);
    check("b2b.spacing", cyc + 1, 5);
    check("b2b.busy", bok, 1);
    check("b2b.second", res_of(0), 16'h42);
    // async reset after chunk 1
    accept_op(0, 2'b01, 16'h7F);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1 check("rst.outs", {res_of(0), flg_of(0), dn_of(0)}, 0);
    @(negedge clk) reset = 0;
    cnt = 0;
    repeat (8) begin @(posedge clk); #1 if (dn0) cnt++; end
    check("rst.no_done", cnt, 0);
    run_op("rst.inc01", 0, 2'b01, 16'h01);
    check("rst.inc01.exact", res_of(0), 16'h02);
    // randomized sweep over all configurations
    for (int d = 0; d < 3; d++) begin
      corners[0] = 0;
      corners[1] = 1;
      corners[2] = 16'((1 << wd[d]) - 1);
      corners[3] = 16'(1 << (wd[d] - 1));
      for (int k = 0; k < 4; k++)
        for (int mm = 0; mm < 4; mm++)
          run_op($sformatf("corner.d%0d.m%0d.k%0d", d, mm, k), d, 2'(mm), corners[k]);
      for (int k = 0; k < 30; k++) begin
        x = 16'($urandom);
        m = 2'($urandom_range(0, 3));
        run_op($sformatf("rand.d%0d.m%0d.x%0h", d, m, x), d, m, x);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
